// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and defaults for the UART receive path
//
// Contents:
//   ST_*            3-bit state codes (IDLE, START, DATA, PARITY, STOP)
//   uart_state_t    enum built on those codes
//   UART_DATA_BITS  default data bits per frame
//   UART_OVERSAMPLE default sample_tick pulses per bit period
//   UART_IDLE_LEVEL level of an idle line
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } uart_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam int   UART_OVERSAMPLE = 16;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser for a single asynchronous bit
//
// Ports:
//   clk    in   1  destination clock
//   rst_n  in   1  asynchronous active-low reset; both flops load RESET_VAL
//   d      in   1  asynchronous input
//   q      out  1  synchronised output, two clk of latency
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - oversampling 8N1 serial receiver with framing error detection
//
// Optional parity stage: define UART_RX_PARITY_EN to add a parity bit between the
// data bits and the stop bit (sense chosen by PARITY_ODD).
//
// Ports:
//   clk          in   1          system clock
//   rst_n        in   1          asynchronous active-low reset
//   sample_tick  in   1          1-clk pulse at OVERSAMPLE x baud; FSM advances only on it
//   rx           in   1          asynchronous serial line, idle high
//   rx_data      out  DATA_BITS  last good byte, held until the next good frame
//   rx_valid     out  1          1-clk pulse, rx_data updated
//   frame_err    out  1          1-clk pulse, stop bit sampled low, frame discarded
//   parity_err   out  1          1-clk pulse with rx_valid on parity mismatch
//   busy         out  1          high whenever the FSM is not idle
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  // START waits half a bit to land mid start bit; every later bit waits a full bit.
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_cfg_check
    $error("uart_rx_frame: OVERSAMPLE must be even and >= 4, PARITY_ODD must be 0 or 1");
  end

  uart_state_t          state, state_nx;
  logic [TW-1:0]        tick_cnt, tick_nx;
  logic [BW-1:0]        bit_cnt, bit_nx;
  logic [DATA_BITS-1:0] shift, shift_nx;
  logic [DATA_BITS-1:0] data_nx;
  logic                 valid_nx;
  logic                 ferr_nx;
  logic                 rx_s;
  logic                 prev_s;

`ifdef UART_RX_PARITY_EN
  logic par_bad, par_bad_nx;
  logic perr_nx;
  logic parity_err_q;
`endif

  uart_sync2 #(
    .RESET_VAL (UART_IDLE_LEVEL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    state_nx = state;
    tick_nx  = tick_cnt;
    bit_nx   = bit_cnt;
    shift_nx = shift;
    data_nx  = rx_data;
    valid_nx = 1'b0;
    ferr_nx  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nx = par_bad;
    perr_nx    = 1'b0;
`endif

    if (sample_tick) begin
      case (state)
        S_IDLE: begin
          // Edge rule: a line that was already low (break) never starts a frame.
          if (!rx_s && prev_s) begin
            state_nx = S_START;
            tick_nx  = '0;
          end
        end

        S_START: begin
          if (tick_cnt == TICK_MID) begin
            tick_nx = '0;
            if (!rx_s) begin
              state_nx = S_DATA;
              bit_nx   = '0;
            end else begin
              state_nx = S_IDLE;
            end
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (tick_cnt == TICK_LAST) begin
            shift_nx = {rx_s, shift[DATA_BITS-1:1]};
            tick_nx  = '0;
            bit_nx   = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_nx = S_PARITY;
`else
              state_nx = S_STOP;
`endif
            end
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick_cnt == TICK_LAST) begin
            // Expected parity bit is XOR of the data, inverted for odd parity.
            par_bad_nx = rx_s ^ (^shift) ^ 1'(PARITY_ODD);
            tick_nx    = '0;
            state_nx   = S_STOP;
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (tick_cnt == TICK_LAST) begin
            if (rx_s) begin
              data_nx  = shift;
              valid_nx = 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_nx  = par_bad;
`endif
            end else begin
              ferr_nx = 1'b1;
            end
            tick_nx  = '0;
            state_nx = S_IDLE;
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end

        default: begin
          state_nx = S_IDLE;
          tick_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      prev_s    <= UART_IDLE_LEVEL;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      tick_cnt  <= tick_nx;
      bit_cnt   <= bit_nx;
      shift     <= shift_nx;
      rx_data   <= data_nx;
      rx_valid  <= valid_nx;
      frame_err <= ferr_nx;
      if (sample_tick) begin
        prev_s <= rx_s;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad      <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad      <= par_bad_nx;
      parity_err_q <= perr_nx;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - self-checking bench for uart_rx_frame against a frame-level model
module tb_uart_rx_frame;

  localparam int OS      = 16;
  localparam int BIT_CLK = 64;
  localparam int PAR_ODD = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
    logic       perr;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  logic [7:0] last_good = 8'h00;

  uart_rx_frame #(
    .DATA_BITS  (8),
    .OVERSAMPLE (OS),
    .PARITY_ODD (PAR_ODD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every output pulse becomes one observed event; a pulse held two cycles shows up twice.
  always @(negedge clk) begin
    if (rst_n && (rx_valid || frame_err || parity_err)) begin
      check("valid_ferr_exclusive", 32'(rx_valid & frame_err), 32'd0);
      check("perr_without_valid", 32'(parity_err & ~rx_valid), 32'd0);
      obs_q.push_back('{frame_err, rx_data, parity_err});
    end
  end

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ 1'(PAR_ODD);
  endfunction

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic idle_clks(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame and records what a correct receiver must report for it.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    logic perr_exp;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_b);
    perr_exp = (par_b != good_par(d));
`else
    perr_exp = 1'b0;
    if (par_b) perr_exp = 1'b0;
`endif
    drive_bit(stop_b);
    if (stop_b) begin
      exp_q.push_back('{1'b0, d, perr_exp});
      last_good = d;
    end else begin
      exp_q.push_back('{1'b1, last_good, 1'b0});
    end
  endtask

  task automatic compare_events(input string tag);
    ev_t e;
    ev_t o;
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_ferr"}, 32'(o.ferr), 32'(e.ferr));
      check({tag, "_data"}, 32'(o.data), 32'(e.data));
      check({tag, "_perr"}, 32'(o.perr), 32'(e.perr));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       stop_b;
    logic       par_b;
    int         gap;

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (6) @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    idle_clks(2 * BIT_CLK);

    send_frame(8'h55, 1'b1, good_par(8'h55));
    idle_clks(BIT_CLK);
    compare_events("t1_0x55");
    check("t1_rx_data", 32'(rx_data), 32'h55);
    check("t1_busy_after", 32'(busy), 32'h0);

    rx = 1'b0;
    repeat (4 * 4) @(negedge clk);
    idle_clks(2 * BIT_CLK);
    compare_events("t2_glitch");
    check("t2_busy_after", 32'(busy), 32'h0);

    send_frame(8'hA3, 1'b0, good_par(8'hA3));
    idle_clks(2 * BIT_CLK);
    compare_events("t3_bad_stop");
    check("t3_rx_data_held", 32'(rx_data), 32'h55);

    send_frame(8'h00, 1'b1, good_par(8'h00));
    send_frame(8'hFF, 1'b1, good_par(8'hFF));
    idle_clks(BIT_CLK);
    compare_events("t4_back_to_back");

    rx = 1'b0;
    repeat (20 * BIT_CLK) @(negedge clk);
    exp_q.push_back('{1'b1, last_good, 1'b0});
    idle_clks(2 * BIT_CLK);
    compare_events("break");
    check("break_busy_after", 32'(busy), 32'h0);

    d = 8'hC6;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (BIT_CLK / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_rx_data", 32'(rx_data), 32'h0);
    check("t5_rst_rx_valid", 32'(rx_valid), 32'h0);
    check("t5_rst_frame_err", 32'(frame_err), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    last_good = 8'h00;
    obs_q.delete();
    idle_clks(BIT_CLK);
    send_frame(8'h3C, 1'b1, good_par(8'h3C));
    idle_clks(BIT_CLK);
    compare_events("t5_after_reset");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    idle_clks(BIT_CLK);
    compare_events("t6_par_bad");
    send_frame(8'h07, 1'b1, 1'b1);
    idle_clks(BIT_CLK);
    compare_events("t6_par_good");
`endif

    for (int n = 0; n < 36; n++) begin
      d      = 8'($urandom);
      stop_b = ($urandom_range(0, 3) != 0);
      par_b  = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
      send_frame(d, stop_b, par_b);
      gap = stop_b ? int'($urandom_range(0, 80)) : 16 + int'($urandom_range(0, 64));
      idle_clks(gap);
      if (n % 6 == 5) begin
        idle_clks(BIT_CLK);
        compare_events("random");
      end
    end
    idle_clks(BIT_CLK);
    compare_events("random_tail");
    check("final_rx_data", 32'(rx_data), 32'(last_good));
    check("final_busy", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
